// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared encodings and types for the counter bank.
package counter_bank_pkg;

    // Configuration write opcodes carried on cfg_op
    typedef enum logic [1:0] {
        OP_LOAD    = 2'd0,
        OP_LIMIT   = 2'd1,
        OP_MODE    = 2'd2,
        OP_CLRFLAG = 2'd3
    } cfg_op_e;

    // Behaviour of a channel when it reaches its terminal value
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Snapshot streamer states
    typedef enum logic {
        SNAP_IDLE   = 1'b0,
        SNAP_STREAM = 1'b1
    } snap_state_e;

    // Decoded per-channel config strobes
    typedef struct packed {
        logic load;
        logic limit_we;
        logic mode_we;
        logic clr_flag;
    } chan_cfg_t;

    // Channel index width, never narrower than one bit
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// counter_bank_chan: one up/down counter with load, limit, wrap/saturate
// mode, registered terminal-count pulse and sticky flag.
module counter_bank_chan
    import counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  chan_cfg_t        cfg,
    input  logic [WIDTH-1:0] cfg_data,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             flag
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    mode_e            mode_q, mode_d;
    logic             flag_q, flag_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] cnt_inc, cnt_dec;

    // Next count, terminal event and config register updates
    always_comb begin
        cnt_d   = cnt_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;
        cnt_inc = cnt_q + WIDTH'(1);
        cnt_dec = cnt_q - WIDTH'(1);

        if (cfg.limit_we) limit_d = cfg_data;
        if (cfg.mode_we)  mode_d  = mode_e'(cfg_data[0]);

        if (cfg.load) begin
            cnt_d = cfg_data;
        end else if (en) begin
            if (dir) begin
                if (cnt_q == limit_q) begin
                    if (mode_q == MODE_WRAP) begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end
                end else begin
                    // Counts above the limit simply roll over at all-ones
                    cnt_d = cnt_inc;
                    tc_d  = (mode_q == MODE_SAT) && (cnt_inc == limit_q);
                end
            end else begin
                if (cnt_q == '0) begin
                    if (mode_q == MODE_WRAP) begin
                        cnt_d = limit_q;
                        tc_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_dec;
                    tc_d  = (mode_q == MODE_SAT) && (cnt_dec == '0);
                end
            end
        end

        // A terminal event on the same edge as a clear keeps the flag set
        flag_d = tc_d ? 1'b1 : (cfg.clr_flag ? 1'b0 : flag_q);
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            limit_q <= '1;
            mode_q  <= MODE_WRAP;
            flag_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            flag_q  <= flag_d;
            tc_q    <= tc_d;
        end
    end

    assign cnt  = cnt_q;
    assign tc   = tc_q;
    assign flag = flag_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: bank of independent up/down counters with config decode,
// interrupt reduction and an optional atomic snapshot streamer.
// Snapshot hardware is built only when COUNTER_BANK_SNAPSHOT_EN is defined.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    localparam int unsigned CH_W     = ch_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [1:0]                cfg_op,
    input  logic [WIDTH-1:0]          cfg_data,
    output logic [CHANNELS*WIDTH-1:0] cnt_o,
    output logic [CHANNELS-1:0]       tc_o,
    output logic                      irq_o,
    input  logic                      snap_req,
    output logic                      snap_busy,
    output logic                      snap_valid,
    input  logic                      snap_ready,
    output logic [WIDTH-1:0]          snap_data,
    output logic [CH_W-1:0]           snap_ch,
    output logic                      snap_last
);

    chan_cfg_t        chan_cfg [CHANNELS];
    logic [WIDTH-1:0] cnt_w    [CHANNELS];
    logic [CHANNELS-1:0] flag_w;

    // Route a config write to its channel; out-of-range indices match none
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            chan_cfg[i] = '0;
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                chan_cfg[i].load     = (cfg_op == OP_LOAD);
                chan_cfg[i].limit_we = (cfg_op == OP_LIMIT);
                chan_cfg[i].mode_we  = (cfg_op == OP_MODE);
                chan_cfg[i].clr_flag = (cfg_op == OP_CLRFLAG);
            end
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
        counter_bank_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[g]),
            .dir      (dir[g]),
            .cfg      (chan_cfg[g]),
            .cfg_data (cfg_data),
            .cnt      (cnt_w[g]),
            .tc       (tc_o[g]),
            .flag     (flag_w[g])
        );
        assign cnt_o[g*WIDTH +: WIDTH] = cnt_w[g];
    end

    assign irq_o = |flag_w;

`ifdef COUNTER_BANK_SNAPSHOT_EN

    snap_state_e      state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] shadow_d [CHANNELS];

    // Snapshot capture and beat sequencing
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        last_d   = last_q;
        shadow_d = shadow_q;

        unique case (state_q)
            SNAP_IDLE: begin
                if (snap_req) begin
                    state_d  = SNAP_STREAM;
                    shadow_d = cnt_w;
                    idx_d    = '0;
                    data_d   = cnt_w[0];
                    last_d   = (CHANNELS == 1);
                end
            end
            SNAP_STREAM: begin
                if (snap_ready) begin
                    if (last_q) begin
                        state_d = SNAP_IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d  = idx_q + CH_W'(1);
                        data_d = shadow_q[idx_d];
                        last_d = (idx_d == CH_W'(CHANNELS - 1));
                    end
                end
            end
        endcase
    end

    // Snapshot state and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SNAP_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            last_q   <= last_d;
            shadow_q <= shadow_d;
        end
    end

    assign snap_busy  = (state_q == SNAP_STREAM);
    assign snap_valid = (state_q == SNAP_STREAM);
    assign snap_data  = data_q;
    assign snap_ch    = idx_q;
    assign snap_last  = last_q;

`else

    assign snap_busy  = 1'b0;
    assign snap_valid = 1'b0;
    assign snap_data  = '0;
    assign snap_ch    = '0;
    assign snap_last  = 1'b0;

    logic unused_snap;
    assign unused_snap = &{1'b0, snap_req, snap_ready};

`endif

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: scoreboard bench for counter_bank (COUNTER_BANK_SNAPSHOT_EN
// selects which snapshot scenarios run).
`timescale 1ns/1ps
module tb_counter_bank;
    import counter_bank_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned N3 = 3;

    typedef struct { int ch; logic [W-1:0] cnt; logic tc; logic irq; } cnt_exp_t;
    typedef struct { logic [1:0] ch; logic [W-1:0] data; logic last; } snap_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0]   en, dir;
    logic           cfg_we;
    logic [1:0]     cfg_ch, cfg_op;
    logic [W-1:0]   cfg_data;
    logic [N*W-1:0] cnt_o;
    logic [N-1:0]   tc_o;
    logic           irq_o;
    logic           snap_req, snap_busy, snap_valid, snap_ready, snap_last;
    logic [W-1:0]   snap_data;
    logic [1:0]     snap_ch;

    logic [N3-1:0]   en3, dir3;
    logic            cfg_we3;
    logic [1:0]      cfg_ch3, cfg_op3;
    logic [W-1:0]    cfg_data3;
    logic [N3*W-1:0] cnt3;
    logic [N3-1:0]   tc3;
    logic            irq3;
    logic            snap_req3, snap_busy3, snap_valid3, snap_ready3, snap_last3;
    logic [W-1:0]    snap_data3;
    logic [1:0]      snap_ch3;

    int checks = 0;
    int failures = 0;
    cnt_exp_t  exp_q[$];
    snap_exp_t snap_q[$];

    counter_bank #(.WIDTH(W), .CHANNELS(N)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_op(cfg_op), .cfg_data(cfg_data),
        .cnt_o(cnt_o), .tc_o(tc_o), .irq_o(irq_o),
        .snap_req(snap_req), .snap_busy(snap_busy), .snap_valid(snap_valid),
        .snap_ready(snap_ready), .snap_data(snap_data), .snap_ch(snap_ch),
        .snap_last(snap_last)
    );

    counter_bank #(.WIDTH(W), .CHANNELS(N3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .dir(dir3),
        .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_op(cfg_op3), .cfg_data(cfg_data3),
        .cnt_o(cnt3), .tc_o(tc3), .irq_o(irq3),
        .snap_req(snap_req3), .snap_busy(snap_busy3), .snap_valid(snap_valid3),
        .snap_ready(snap_ready3), .snap_data(snap_data3), .snap_ch(snap_ch3),
        .snap_last(snap_last3)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = '0; dir = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_op = '0; cfg_data = '0;
        snap_req = 1'b0; snap_ready = 1'b0;
        en3 = '0; dir3 = '0; cfg_we3 = 1'b0; cfg_ch3 = '0; cfg_op3 = '0; cfg_data3 = '0;
        snap_req3 = 1'b0; snap_ready3 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] op, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_op = op; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        checks++;
        if (cnt_o !== '0 || tc_o !== '0 || irq_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_counts got cnt=%h tc=%b irq=%b want 0", cnt_o, tc_o, irq_o);
        end
        checks++;
        if ({snap_busy, snap_valid, snap_last} !== 3'b000 || snap_data !== '0 || snap_ch !== '0) begin
            failures++;
            $display("FAIL reset_snap got busy=%b valid=%b last=%b data=%h ch=%0d want 0",
                     snap_busy, snap_valid, snap_last, snap_data, snap_ch);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_default();
        cnt_exp_t e;
        do_reset();
        en = 4'b0001; dir = 4'b0001;
        for (int k = 1; k <= 258; k++) begin
            exp_q.push_back('{0, W'(k % 256), (k == 256), (k >= 256)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL wrap_default step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
        en = '0;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_op = OP_CLRFLAG; cfg_data = 8'hFF;
        exp_q.push_back('{0, 8'd2, 1'b0, 1'b0});
        tick();
        cfg_we = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
            failures++;
            $display("FAIL clrflag got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                     cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
        end
    endtask

    task automatic test_limit_modes();
        cnt_exp_t e;
        do_reset();
        cfg_write(0, OP_LIMIT, 8'd5);
        en = 4'b0001; dir = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            exp_q.push_back('{0, W'(k % 6), (k % 6 == 0), (k >= 6)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL limit_wrap step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
        en = '0;
        cfg_write(0, OP_MODE, 8'd1);
        cfg_write(0, OP_LOAD, 8'd0);
        cfg_write(0, OP_CLRFLAG, 8'd0);
        en = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            exp_q.push_back('{0, W'((k < 5) ? k : 5), (k == 5), (k >= 5)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL limit_sat step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
    endtask

    task automatic test_down();
        cnt_exp_t e;
        int wc [5] = '{1, 0, 9, 8, 7};
        int sc [3] = '{1, 0, 0};
        do_reset();
        cfg_write(2, OP_LOAD, 8'd2);
        cfg_write(2, OP_LIMIT, 8'd9);
        en = 4'b0100; dir = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back('{2, W'(wc[k]), (k == 2), (k >= 2)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL down_wrap step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
        // load on a counting cycle takes priority, counting resumes after
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_op = OP_LOAD; cfg_data = 8'd50;
        exp_q.push_back('{2, 8'd50, 1'b0, 1'b1});
        exp_q.push_back('{2, 8'd49, 1'b0, 1'b1});
        for (int k = 0; k < 2; k++) begin
            tick();
            cfg_we = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL load_priority step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
        en = '0;
        cfg_write(2, OP_MODE, 8'd1);
        cfg_write(2, OP_LOAD, 8'd2);
        cfg_write(2, OP_CLRFLAG, 8'd0);
        en = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{2, W'(sc[k]), (k == 1), (k >= 1)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL down_sat step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
    endtask

    task automatic test_over_limit();
        cnt_exp_t e;
        int oc [8] = '{255, 0, 1, 2, 3, 4, 5, 0};
        do_reset();
        cfg_write(3, OP_LIMIT, 8'd5);
        cfg_write(3, OP_LOAD, 8'd254);
        en = 4'b1000; dir = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back('{3, W'(oc[k]), (k == 7), (k == 7)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL over_limit_wrap step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
        en = '0;
        cfg_write(3, OP_MODE, 8'd1);
        cfg_write(3, OP_LOAD, 8'd254);
        cfg_write(3, OP_CLRFLAG, 8'd0);
        en = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{3, W'(oc[k]), 1'b0, 1'b0});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL over_limit_sat step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
    endtask

    task automatic test_tc_clr_race();
        cnt_exp_t e;
        do_reset();
        cfg_write(1, OP_LIMIT, 8'd2);
        en = 4'b0010; dir = 4'b0010;
        exp_q.push_back('{1, 8'd1, 1'b0, 1'b0});
        exp_q.push_back('{1, 8'd2, 1'b0, 1'b0});
        exp_q.push_back('{1, 8'd0, 1'b1, 1'b1});
        exp_q.push_back('{1, 8'd0, 1'b0, 1'b1});
        exp_q.push_back('{1, 8'd0, 1'b0, 1'b0});
        for (int k = 0; k < 5; k++) begin
            cfg_we = (k == 2 || k == 4); cfg_ch = 2'd1; cfg_op = OP_CLRFLAG; cfg_data = 8'd0;
            if (k >= 3) en = '0;
            tick();
            cfg_we = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (cnt_o[e.ch*W +: W] !== e.cnt || tc_o[e.ch] !== e.tc || irq_o !== e.irq) begin
                failures++;
                $display("FAIL tc_clr_race step=%0d got cnt=%0d tc=%b irq=%b want cnt=%0d tc=%b irq=%b",
                         k, cnt_o[e.ch*W +: W], tc_o[e.ch], irq_o, e.cnt, e.tc, e.irq);
            end
        end
    endtask

    task automatic test_bad_channel();
        do_reset();
        cfg_we3 = 1'b1; cfg_ch3 = 2'd3;
        cfg_op3 = OP_LOAD;  cfg_data3 = 8'd77; tick();
        cfg_op3 = OP_LIMIT; cfg_data3 = 8'd0;  tick();
        cfg_op3 = OP_MODE;  cfg_data3 = 8'd1;  tick();
        cfg_we3 = 1'b0;
        checks++;
        if (cnt3 !== '0 || irq3 !== 1'b0) begin
            failures++;
            $display("FAIL bad_ch_load got cnt=%h irq=%b want 0", cnt3, irq3);
        end
        en3 = 3'b111; dir3 = 3'b111;
        tick();
        en3 = '0;
        checks++;
        if (cnt3 !== {8'd1, 8'd1, 8'd1} || tc3 !== '0) begin
            failures++;
            $display("FAIL bad_ch_limit got cnt=%h tc=%b want 010101 tc=000", cnt3, tc3);
        end
        cfg_we3 = 1'b1; cfg_ch3 = 2'd2; cfg_op3 = OP_LOAD; cfg_data3 = 8'd9;
        tick();
        cfg_we3 = 1'b0;
        checks++;
        if (cnt3 !== {8'd9, 8'd1, 8'd1}) begin
            failures++;
            $display("FAIL good_ch_load got cnt=%h want 090101", cnt3);
        end
    endtask

`ifdef COUNTER_BANK_SNAPSHOT_EN
    task automatic test_snapshot();
        snap_exp_t s;
        int cyc;
        logic r;
        do_reset();
        cfg_write(0, OP_LOAD, 8'd3);
        cfg_write(1, OP_LOAD, 8'd7);
        cfg_write(2, OP_LOAD, 8'd11);
        cfg_write(3, OP_LOAD, 8'd15);
        en = 4'hF; dir = 4'hF; snap_req = 1'b1;
        snap_q.push_back('{2'd0, 8'd3, 1'b0});
        snap_q.push_back('{2'd1, 8'd7, 1'b0});
        snap_q.push_back('{2'd2, 8'd11, 1'b0});
        snap_q.push_back('{2'd3, 8'd15, 1'b1});
        tick();
        en = '0; snap_req = 1'b0;
        checks++;
        if (cnt_o !== {8'd16, 8'd12, 8'd8, 8'd4} || snap_busy !== 1'b1) begin
            failures++;
            $display("FAIL snap_start got cnt=%h busy=%b want 100c0804 busy=1", cnt_o, snap_busy);
        end
        cyc = 0;
        while (snap_q.size() > 0 && cyc < 40) begin
            r = cyc[0];
            snap_req = (cyc == 3);
            s = snap_q[0];
            checks++;
            if (snap_valid !== 1'b1 || snap_ch !== s.ch || snap_data !== s.data || snap_last !== s.last) begin
                failures++;
                $display("FAIL snap_beat cyc=%0d got v=%b ch=%0d data=%0d last=%b want v=1 ch=%0d data=%0d last=%b",
                         cyc, snap_valid, snap_ch, snap_data, snap_last, s.ch, s.data, s.last);
            end
            snap_ready = r;
            if (r && snap_valid) void'(snap_q.pop_front());
            tick();
            cyc++;
        end
        snap_req = 1'b0; snap_ready = 1'b0;
        if (snap_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL snap_timeout got %0d beats left want 0", snap_q.size());
            snap_q.delete();
        end
        checks++;
        if (snap_valid !== 1'b0 || snap_busy !== 1'b0) begin
            failures++;
            $display("FAIL snap_end got v=%b busy=%b want 0", snap_valid, snap_busy);
        end
        tick();
        checks++;
        if (snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL snap_req_ignored got v=%b want 0", snap_valid);
        end
    endtask

    task automatic test_back_to_back();
        snap_exp_t s;
        snap_ready = 1'b1; snap_req = 1'b1;
        for (int c = 0; c < 4; c++) snap_q.push_back('{2'(c), W'(4 * (c + 1)), (c == 3)});
        tick();
        snap_req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s = snap_q.pop_front();
            checks++;
            if (snap_valid !== 1'b1 || snap_ch !== s.ch || snap_data !== s.data || snap_last !== s.last) begin
                failures++;
                $display("FAIL b2b_beat b=%0d got v=%b ch=%0d data=%0d last=%b want v=1 ch=%0d data=%0d last=%b",
                         b, snap_valid, snap_ch, snap_data, snap_last, s.ch, s.data, s.last);
            end
            tick();
        end
        snap_ready = 1'b0;
        checks++;
        if (snap_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got v=%b want 0", snap_valid);
        end
    endtask
`else
    task automatic test_snap_disabled();
        do_reset();
        snap_req = 1'b1; snap_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({snap_valid, snap_busy, snap_last} !== 3'b000 || snap_data !== '0 || snap_ch !== '0) begin
                failures++;
                $display("FAIL snap_disabled k=%0d got v=%b busy=%b last=%b data=%h ch=%0d want 0",
                         k, snap_valid, snap_busy, snap_last, snap_data, snap_ch);
            end
        end
        snap_req = 1'b0; snap_ready = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        cfg_write(0, OP_LOAD, 8'd254);
        en = 4'b0001; dir = 4'b0001;
        tick(); tick(); tick();
`ifdef COUNTER_BANK_SNAPSHOT_EN
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        checks++;
        if (snap_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_stream got v=%b want 1", snap_valid);
        end
`endif
        checks++;
        if (irq_o !== 1'b1 || cnt_o[W-1:0] === 8'd0) begin
            failures++;
            $display("FAIL pre_reset_state got irq=%b cnt=%0d want irq=1 cnt!=0", irq_o, cnt_o[W-1:0]);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_o !== '0 || tc_o !== '0 || irq_o !== 1'b0 || snap_valid !== 1'b0 || snap_busy !== 1'b0
            || snap_last !== 1'b0 || snap_data !== '0 || snap_ch !== '0) begin
            failures++;
            $display("FAIL async_reset got cnt=%h tc=%b irq=%b v=%b busy=%b last=%b data=%h ch=%0d want 0",
                     cnt_o, tc_o, irq_o, snap_valid, snap_busy, snap_last, snap_data, snap_ch);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_wrap_default();
        test_limit_modes();
        test_down();
        test_over_limit();
        test_tc_clr_race();
        test_bad_channel();
`ifdef COUNTER_BANK_SNAPSHOT_EN
        test_snapshot();
        test_back_to_back();
`else
        test_snap_disabled();
`endif
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of independent up/down counters. Next generation of the top-level sanity counter, intended to sit behind the tile's I/O mux as the shared event/cycle counting resource. Each channel adds runtime-programmable load, terminal limit, wrap/saturate mode, terminal-count pulses and a sticky interrupt. An optional atomic snapshot captures every channel on the same edge and streams the values out over a valid/ready port.

## Interface
- WIDTH, 8, counter width in bits (2..32)
- CHANNELS, 4, number of counter channels (1..16)
- CH_W, $clog2(CHANNELS) min 1, channel index width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- en  in  CHANNELS  per-channel count enable
- dir  in  CHANNELS  per-channel direction, 1=up, 0=down
- cfg_we  in  1  single-cycle config write strobe
- cfg_ch  in  CH_W  target channel
- cfg_op  in  2  0=LOAD, 1=LIMIT, 2=MODE, 3=CLRFLAG
- cfg_data  in  WIDTH  write data
- cnt_o  out  CHANNELS*WIDTH  live counts, channel i at [i*WIDTH +: WIDTH]
- tc_o  out  CHANNELS  one-cycle terminal-count pulses, registered
- irq_o  out  1  OR of sticky per-channel flags
- snap_req  in  1  snapshot request
- snap_busy  out  1  snapshot stream in progress
- snap_valid  out  1  stream data valid
- snap_ready  in  1  stream consumer ready
- snap_data  out  WIDTH  captured count
- snap_ch  out  CH_W  channel index of snap_data
- snap_last  out  1  marks final channel beat

## Operation
- Reset values:
  - cnt 0, limit all-ones, mode wrap, flags 0.
  - tc_o 0, irq_o 0.
  - snap_busy/snap_valid/snap_last 0; snap_data 0; snap_ch 0.
- Per channel, per edge, priority: cfg LOAD to this channel > counting. When LOAD hits, cnt=cfg_data and no count occurs that cycle.
- LIMIT sets the limit. MODE: cfg_data[0] 1=saturate, 0=wrap. CLRFLAG clears the sticky flag and ignores cfg_data.
- cfg_ch >= CHANNELS: write ignored.
- Up count (en=1, dir=1):
  - cnt==limit: wrap mode goes to 0 with tc; saturate mode holds with no tc.
  - Otherwise cnt+1 modulo 2^WIDTH.
  - Entering limit by counting in saturate mode raises tc.
- Down count (en=1, dir=0):
  - cnt==0: wrap mode goes to limit with tc; saturate mode holds with no tc.
  - Otherwise cnt-1.
  - Entering 0 by counting in saturate mode raises tc.
- Limit compare is equality only. If cnt>limit while counting up, the count runs to all-ones then wraps to 0 with no tc, in either mode.
- Any tc sets the channel's sticky flag. tc and CLRFLAG on the same channel in the same cycle: set wins.
- Snapshot FSM has states IDLE and STREAM.
  - IDLE: snap_req=1 copies every cnt register (its pre-edge value) into shadow regs on that edge and moves to STREAM with index 0.
  - STREAM: snap_valid=1, snap_data=shadow[idx], snap_ch=idx, snap_last=(idx==CHANNELS-1).
  - On valid&ready: idx+1, or on the last beat return to IDLE.
  - snap_req while in STREAM is ignored.
  - Counting and cfg writes continue during STREAM and do not alter shadow regs.

## Timing
- cnt_o is direct register output, updated the edge after the enable/cfg condition.
- tc_o is asserted the cycle after the wrap/entry edge, for exactly one cycle.
- irq_o is a combinational OR of flag registers, so it rises in the same cycle as tc_o.
- Snapshot: first beat valid the cycle after the snap_req edge. Throughput is 1 beat/cycle with snap_ready held high, so CHANNELS cycles for a full stream.
- snap_data/snap_ch are stable while valid && !ready.
- Async reset mid-stream aborts to IDLE immediately with snap_valid=0. Reset release is synchronised externally.

## Configuration
- COUNTER_BANK_SNAPSHOT_EN defined: shadow registers and snapshot FSM are built.
- COUNTER_BANK_SNAPSHOT_EN undefined: no shadow regs or FSM. snap_busy/snap_valid/snap_last/snap_data/snap_ch are tied 0, and snap_req/snap_ready are ignored.
- Counting behaviour is identical in both builds.

## Structure
- counter_bank_pkg: cfg_op encodings (OP_LOAD, OP_LIMIT, OP_MODE, OP_CLRFLAG), mode enum (MODE_WRAP, MODE_SAT), snapshot state enum.
- Sub-module counter_bank_chan: one channel holding cnt, limit, mode, flag and tc logic, instantiated CHANNELS times via generate.
- Top level holds cfg decode, the irq reduction and the snapshot FSM.

## Test plan
- Reset, then en[0]=1 up, default limit, WIDTH=8: cnt 255->0 at cycle 256; tc_o[0] pulses once; irq_o=1 until CLRFLAG ch0.
- LIMIT=5, wrap, up: sequence 0..5,0; tc each 6 cycles. Switch to MODE sat: holds at 5 with exactly one tc on entry.
- Down mode, LOAD 2, limit 9, wrap: 2,1,0,9,8; tc after the 0->9 edge. LOAD issued on a counting cycle wins over the count.
- Simultaneous tc and CLRFLAG on ch1: flag remains 1. cfg_ch=CHANNELS (non-power-of-2 build, e.g. 3): no state change.
- Snapshot with counts {3,7,11,15}: snap_req, then 4 beats ch0..3 with those values and snap_last on beat 3. snap_ready toggled 0/1 holds data stable. Second snap_req mid-stream is ignored.
- Assert rst_n low mid-stream and mid-count: all outputs go to reset values asynchronously. Build without COUNTER_BANK_SNAPSHOT_EN: snap_valid stays 0 after snap_req.
